// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive-side monitor for a multiplexed 4-digit 7-segment bus.
// Samples the scanned digit patterns, decodes active-low segment codes to BCD,
// assembles d0..d3 frames and publishes a score once it has been stable for
// STABLE_FRAMES consecutive identical frames.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   seg_in[7:0]  segment pattern, active-low {dp,g,f,e,d,c,b,a}
//   sel_in[3:0]  digit select, active-low one-hot (0111=d0 ... 1110=d3)
//   score_bcd    confirmed score {d3,d2,d1,d0}
//   score_valid  score_bcd holds a confirmed value
//   score_update 1-cycle pulse when score_bcd changes value
//   seg_error    1-cycle pulse on undecodable pattern or out-of-order digit
//   scan_lost    level, no sel change for SCAN_TIMEOUT cycles
module seg_scan_decoder #(
  parameter int unsigned SCAN_TIMEOUT  = 400_000,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  sel_in,
  output logic [15:0] score_bcd,
  output logic        score_valid,
  output logic        score_update,
  output logic        seg_error,
  output logic        scan_lost
);

  localparam int unsigned TO_W = 20;
  localparam int unsigned MC_W = 4;

  // State code equals the index of the digit expected next.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] D0   = 2'd1;
  localparam logic [1:0] D1   = 2'd2;
  localparam logic [1:0] D2   = 2'd3;

  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(SCAN_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX    = {TO_W{1'b1}};
  localparam logic [MC_W-1:0] MC_TARGET = MC_W'(STABLE_FRAMES);

  // Returns {good, digit}.
  function automatic logic [4:0] decode(input logic [7:0] p);
    logic [4:0] r;
    case (p)
      8'hC0:   r = {1'b1, 4'd0};
      8'hF9:   r = {1'b1, 4'd1};
      8'hA4:   r = {1'b1, 4'd2};
      8'hB0:   r = {1'b1, 4'd3};
      8'h99:   r = {1'b1, 4'd4};
      8'h92:   r = {1'b1, 4'd5};
      8'h82:   r = {1'b1, 4'd6};
      8'hF8:   r = {1'b1, 4'd7};
      8'h80:   r = {1'b1, 4'd8};
      8'h90:   r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  logic [7:0]      s_seg;
  logic [3:0]      s_sel, prev_sel;
  logic [1:0]      state, state_d;
  logic [11:0]     cap, cap_d;          // {d2,d1,d0} captured so far
  logic [15:0]     last_frame, last_frame_d;
  logic [MC_W-1:0] match_cnt, match_cnt_d;
  logic [TO_W-1:0] to_cnt, to_cnt_d;
  logic [15:0]     score_d;
  logic            valid_d, update_d, error_d, lost_d;

  logic            ev_c;
  logic            sel_ok_c;
  logic [1:0]      idx_c;
  logic [4:0]      dec_c;
  logic [15:0]     cand_c;
  logic [MC_W-1:0] mc_n_c;

  assign ev_c  = (s_sel != prev_sel);
  assign dec_c = decode(s_seg);

  // Position of the selected digit; sel_ok_c flags a legal one-hot-low select.
  always_comb begin
    sel_ok_c = 1'b1;
    idx_c    = 2'd0;
    case (s_sel)
      4'b0111: idx_c = 2'd0;
      4'b1011: idx_c = 2'd1;
      4'b1101: idx_c = 2'd2;
      4'b1110: idx_c = 2'd3;
      default: sel_ok_c = 1'b0;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state;
    cap_d        = cap;
    last_frame_d = last_frame;
    match_cnt_d  = match_cnt;
    to_cnt_d     = to_cnt;
    score_d      = score_bcd;
    valid_d      = score_valid;
    update_d     = 1'b0;
    error_d      = 1'b0;
    lost_d       = scan_lost;
    cand_c       = {dec_c[3:0], cap};
    mc_n_c       = match_cnt;

    if (ev_c) begin
      to_cnt_d = '0;
      lost_d   = 1'b0;
      if (!sel_ok_c) begin
        // Blank or restart from the driver.
        state_d     = IDLE;
        match_cnt_d = '0;
        score_d     = '0;
        valid_d     = 1'b0;
      end else if (dec_c[4] && (idx_c == state)) begin
        case (state)
          IDLE: cap_d[3:0]  = dec_c[3:0];
          D0:   cap_d[7:4]  = dec_c[3:0];
          D1:   cap_d[11:8] = dec_c[3:0];
          default: ;
        endcase
        state_d = state + 2'd1;
        if (state == D2) begin
          // d3 captured: frame complete.
          if (cand_c == last_frame) begin
            mc_n_c = (match_cnt >= MC_TARGET) ? MC_TARGET : match_cnt + MC_W'(1);
          end else begin
            last_frame_d = cand_c;
            mc_n_c       = MC_W'(1);
          end
          match_cnt_d = mc_n_c;
          if ((mc_n_c == MC_TARGET) && (!score_valid || (cand_c != score_bcd))) begin
            score_d  = cand_c;
            valid_d  = 1'b1;
            update_d = 1'b1;
          end
        end
      end else begin
        // In IDLE only a bad code on d0 is an error; mid-frame anything here is.
        if ((state != IDLE) || (idx_c == 2'd0)) begin
          error_d = 1'b1;
        end
        if ((idx_c == 2'd0) && dec_c[4]) begin
          cap_d[3:0] = dec_c[3:0];
          state_d    = D0;
        end else begin
          state_d = IDLE;
        end
      end
    end else begin
      if (to_cnt != TO_MAX) begin
        to_cnt_d = to_cnt + TO_W'(1);
      end
      if (to_cnt == TO_LAST) begin
        lost_d      = 1'b1;
        valid_d     = 1'b0;
        state_d     = IDLE;
        match_cnt_d = '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_seg        <= '0;
      s_sel        <= '0;
      prev_sel     <= '0;
      state        <= IDLE;
      cap          <= '0;
      last_frame   <= '0;
      match_cnt    <= '0;
      to_cnt       <= '0;
      score_bcd    <= '0;
      score_valid  <= 1'b0;
      score_update <= 1'b0;
      seg_error    <= 1'b0;
      scan_lost    <= 1'b0;
    end else begin
      s_seg        <= seg_in;
      s_sel        <= sel_in;
      prev_sel     <= s_sel;
      state        <= state_d;
      cap          <= cap_d;
      last_frame   <= last_frame_d;
      match_cnt    <= match_cnt_d;
      to_cnt       <= to_cnt_d;
      score_bcd    <= score_d;
      score_valid  <= valid_d;
      score_update <= update_d;
      seg_error    <= error_d;
      scan_lost    <= lost_d;
    end
  end

endmodule
